// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: fetch/decode/execute/memory/writeback FSM sharing one ALU.
// Define MIPS_PERF_COUNTERS_EN to build the cycle and retired-instruction counters.
module mips_multicycle_core #(
  parameter int          PROGRAM_DEPTH = 64,
  parameter int          DATA_DEPTH    = 256,
  parameter logic [31:0] RESET_PC      = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE     = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] alu_result_o,
  output logic [31:0] pc_o,
  output logic [2:0]  state_o,
  output logic        retire_o,
  output logic        illegal_o,
  output logic [31:0] cycle_count_o,
  output logic [31:0] instr_count_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_NOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;

  localparam int PW = (PROGRAM_DEPTH > 1) ? $clog2(PROGRAM_DEPTH) : 1;
  localparam int DW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;

  logic [31:0] program_rom [PROGRAM_DEPTH];
  logic [31:0] data_ram [DATA_DEPTH];
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d;
  logic        illegal_q, illegal_d;

  logic [5:0]    opcode, funct;
  logic [4:0]    rs, rt, rd, shamt, dest;
  logic [15:0]   imm;
  logic [25:0]   jaddr;
  logic [31:0]   imm_sext, imm_zext, wb_data;
  logic [31:0]   rom_word, ram_word;
  logic [PW-1:0] rom_index;
  logic [DW-1:0] ram_index;
  logic          is_rtype, is_imm_op, is_mem, is_branch, is_jump, is_legal, branch_taken;
  logic          rf_we, ram_we;
  logic [31:0]   alu_a, alu_b, alu_y;
  logic [2:0]    alu_op;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign shamt    = ir_q[10:6];
  assign funct    = ir_q[5:0];
  assign imm      = ir_q[15:0];
  assign jaddr    = ir_q[25:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};
  assign dest     = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_data  = (opcode == OP_LW) ? mdr_q : alu_out_q;

  // Memory word indices wrap modulo the array depth, relative to each region's base.
  assign rom_word  = (pc_q - RESET_PC) >> 2;
  assign rom_index = PW'(rom_word % 32'(PROGRAM_DEPTH));
  assign ram_word  = (alu_out_q - DATA_BASE) >> 2;
  assign ram_index = DW'(ram_word % 32'(DATA_DEPTH));

  always_comb begin
    is_rtype     = (opcode == OP_RTYPE) &&
                   (funct inside {FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR});
    is_imm_op    = opcode inside {OP_ADDI, OP_ORI, OP_LUI};
    is_mem       = opcode inside {OP_LW, OP_SW};
    is_branch    = opcode inside {OP_BEQ, OP_BNE};
    is_jump      = (opcode == OP_J);
    is_legal     = is_rtype || is_imm_op || is_mem || is_branch || is_jump;
    branch_taken = (opcode == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);
  end

  // Operand steering for the shared ALU; shifts move alu_b by alu_a[4:0].
  always_comb begin
    alu_a  = pc_q;
    alu_b  = 32'd4;
    alu_op = ALU_ADD;
    case (state_q)
      S_DECODE: alu_b = {imm_sext[29:0], 2'b00};
      S_EXEC: begin
        alu_a = a_q;
        alu_b = b_q;
        if (opcode == OP_RTYPE) begin
          case (funct)
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLL:  begin alu_op = ALU_SLL; alu_a = {27'd0, shamt}; end
            FN_SRL:  begin alu_op = ALU_SRL; alu_a = {27'd0, shamt}; end
            default: alu_op = ALU_ADD;
          endcase
        end else if (opcode == OP_ORI) begin
          alu_op = ALU_OR;
          alu_b  = imm_zext;
        end else if (opcode == OP_LUI) begin
          alu_op = ALU_SLL;
          alu_a  = 32'd16;
          alu_b  = imm_zext;
        end else begin
          alu_b = imm_sext;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_NOR: alu_y = ~(alu_a | alu_b);
      ALU_SLL: alu_y = alu_b << alu_a[4:0];
      ALU_SRL: alu_y = alu_b >> alu_a[4:0];
      default: alu_y = alu_a + alu_b;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    mdr_d     = mdr_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_out_d = alu_out_q;
    illegal_d = illegal_q;
    rf_we     = 1'b0;
    ram_we    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = program_rom[rom_index];
        pc_d    = alu_y;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d       = regs_q[rs];
        b_d       = regs_q[rt];
        alu_out_d = alu_y;
        if (!is_legal) begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          if (branch_taken) pc_d = alu_out_q;
          state_d = S_FETCH;
        end else if (is_jump) begin
          pc_d    = {pc_q[31:28], jaddr, 2'b00};
          state_d = S_FETCH;
        end else begin
          alu_out_d = alu_y;
          state_d   = is_mem ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        if (opcode == OP_SW) begin
          ram_we  = 1'b1;
          state_d = S_FETCH;
        end else begin
          mdr_d   = data_ram[ram_index];
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we   = (dest != 5'd0);
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (rf_we) regs_d[dest] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      mdr_q     <= mdr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      illegal_q <= illegal_d;
      regs_q    <= regs_d;
    end
  end

  // RAM is not cleared by reset, but a store landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!reset && ram_we) data_ram[ram_index] <= b_q;
  end

  assign retire_o = ((state_q == S_DECODE) && !is_legal) ||
                    ((state_q == S_EXEC) && (is_branch || is_jump)) ||
                    ((state_q == S_MEM) && (opcode == OP_SW)) ||
                    (state_q == S_WB);

  assign alu_result_o = alu_out_q;
  assign pc_o         = pc_q;
  assign state_o      = state_q;
  assign illegal_o    = illegal_q;

`ifdef MIPS_PERF_COUNTERS_EN
  logic [31:0] cycle_count_q, cycle_count_d, instr_count_q, instr_count_d;

  always_comb begin
    cycle_count_d = cycle_count_q + 32'd1;
    instr_count_d = instr_count_q + {31'd0, retire_o};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign cycle_count_o = cycle_count_q;
  assign instr_count_o = instr_count_q;
`else
  assign cycle_count_o = '0;
  assign instr_count_o = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core: an instruction-level MIPS model
// predicts per-cycle state/retire/PC/ALUOut plus register file, RAM and counters.
module tb_mips_multicycle_core;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam int          PDEPTH    = 64;
  localparam int          DDEPTH    = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] alu_result_o, pc_o, cycle_count_o, instr_count_o;
  logic [2:0]  state_o;
  logic        retire_o, illegal_o;

  int checks = 0;
  int failures = 0;

  // Architectural model state.
  logic [31:0] m_rom [PDEPTH];
  logic [31:0] m_ram [DDEPTH];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc;
  logic        m_illegal;
  int          m_cycles, m_retired, m_last_cpi;

  // Expectations for the instruction currently being executed.
  int          exp_cpi;
  logic [2:0]  exp_seq [5];
  logic [31:0] exp_alu;
  logic        exp_alu_valid, exp_sw;
  logic [7:0]  exp_ram_idx;

  mips_multicycle_core dut (
    .clk           (clk),
    .reset         (reset),
    .alu_result_o  (alu_result_o),
    .pc_o          (pc_o),
    .state_o       (state_o),
    .retire_o      (retire_o),
    .illegal_o     (illegal_o),
    .cycle_count_o (cycle_count_o),
    .instr_count_o (instr_count_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_rom(input int idx, input logic [31:0] word);
    dut.program_rom[idx] = word;
    m_rom[idx] = word;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_pc      = RESET_PC;
    m_illegal = 1'b0;
    m_cycles  = 0;
    m_retired = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    @(negedge clk);
  endtask

  function automatic logic [7:0] ram_idx(input logic [31:0] addr);
    logic [31:0] w;
    w = ((addr - DATA_BASE) >> 2) % DDEPTH;
    return w[7:0];
  endfunction

  // Executes one instruction at ISA level and records what the core must show.
  task automatic model_step();
    logic [31:0] ins, pc4, a, b, sext, res, addr, w;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, wreg;
    logic        legal, wr;
    w    = ((m_pc - RESET_PC) >> 2) % PDEPTH;
    ins  = m_rom[w[5:0]];
    pc4  = m_pc + 32'd4;
    op   = ins[31:26];
    rs   = ins[25:21];
    rt   = ins[20:16];
    rd   = ins[15:11];
    sh   = ins[10:6];
    fn   = ins[5:0];
    a    = m_regs[rs];
    b    = m_regs[rt];
    sext = {{16{ins[15]}}, ins[15:0]};
    legal = 1'b1;
    wr    = 1'b0;
    wreg  = rt;
    res   = '0;
    exp_sw = 1'b0;
    exp_alu_valid = 1'b1;
    exp_alu = pc4 + (sext << 2);
    m_pc = pc4;
    exp_cpi = 4;
    case (op)
      6'h00: begin
        wr = 1'b1;
        wreg = rd;
        case (fn)
          6'h20: res = a + b;
          6'h22: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h27: res = ~(a | b);
          6'h00: res = b << sh;
          6'h02: res = b >> sh;
          default: legal = 1'b0;
        endcase
        exp_alu = res;
      end
      6'h08: begin wr = 1'b1; res = a + sext; exp_alu = res; end
      6'h0D: begin wr = 1'b1; res = a | {16'h0, ins[15:0]}; exp_alu = res; end
      6'h0F: begin wr = 1'b1; res = {ins[15:0], 16'h0}; exp_alu = res; end
      6'h23: begin
        addr = a + sext;
        wr = 1'b1;
        res = m_ram[ram_idx(addr)];
        exp_alu = addr;
        exp_cpi = 5;
      end
      6'h2B: begin
        addr = a + sext;
        exp_ram_idx = ram_idx(addr);
        m_ram[exp_ram_idx] = b;
        exp_alu = addr;
        exp_sw = 1'b1;
      end
      6'h04: begin exp_cpi = 3; if (a == b) m_pc = pc4 + (sext << 2); end
      6'h05: begin exp_cpi = 3; if (a != b) m_pc = pc4 + (sext << 2); end
      6'h02: begin exp_cpi = 3; m_pc = {pc4[31:28], ins[25:0], 2'b00}; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      exp_cpi = 2;
      m_illegal = 1'b1;
      exp_alu_valid = 1'b0;
      wr = 1'b0;
      m_pc = pc4;
    end
    if (wr && wreg != 5'd0) m_regs[wreg] = res;
    exp_seq[0] = 3'd0;
    exp_seq[1] = 3'd1;
    exp_seq[2] = 3'd2;
    exp_seq[3] = exp_sw ? 3'd3 : (exp_cpi == 5 ? 3'd3 : 3'd4);
    exp_seq[4] = 3'd4;
    m_cycles += exp_cpi;
    m_retired++;
    m_last_cpi = exp_cpi;
  endtask

  // Runs n instructions, comparing every cycle; entered and left at the negedge of a FETCH cycle.
  task automatic apply_stimulus(input int n);
    logic [31:0] pc_start;
    int cyc0, ret0, mism, first;
    for (int t = 0; t < n; t++) begin
      pc_start = m_pc;
      cyc0 = m_cycles;
      ret0 = m_retired;
      model_step();
      for (int k = 0; k < exp_cpi; k++) begin
        if (k > 0) @(negedge clk);
        check_output("state", {29'd0, state_o}, {29'd0, exp_seq[k]});
        check_output("retire", {31'd0, retire_o}, (k == exp_cpi - 1) ? 32'd1 : 32'd0);
        if (k == 0) begin
          check_output("pc_at_fetch", pc_o, pc_start);
`ifdef MIPS_PERF_COUNTERS_EN
          check_output("cycle_count", cycle_count_o, 32'(cyc0));
          check_output("instr_count", instr_count_o, 32'(ret0));
`else
          check_output("cycle_count_off", cycle_count_o + 32'(cyc0 - cyc0), 32'd0);
          check_output("instr_count_off", instr_count_o + 32'(ret0 - ret0), 32'd0);
`endif
        end
        if (k == exp_cpi - 1 && exp_alu_valid) check_output("alu_result", alu_result_o, exp_alu);
      end
      @(negedge clk);
      mism = 0;
      first = -1;
      for (int i = 0; i < 32; i++) begin
        if (dut.regs_q[i] !== m_regs[i]) begin
          mism++;
          if (first < 0) first = i;
        end
      end
      if (first >= 0)
        $display("[TB] reg %0d dut=%h model=%h", first, dut.regs_q[first], m_regs[first]);
      check_output("regfile_mismatches", 32'(mism), 32'd0);
      check_output("illegal", {31'd0, illegal_o}, {31'd0, m_illegal});
      if (exp_sw) check_output("ram_store", dut.data_ram[exp_ram_idx], m_ram[exp_ram_idx]);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm, br;
    int sel;
    sel = $urandom_range(0, 19);
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    sh  = 5'($urandom);
    imm = 16'($urandom);
    br  = 16'($urandom_range(0, 8)) - 16'd4;
    case (sel)
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4:  return {6'h00, rs, rt, rd, 5'd0, 6'h27};
      5:  return {6'h00, 5'd0, rt, rd, sh, 6'h00};
      6:  return {6'h00, 5'd0, rt, rd, sh, 6'h02};
      9:  return {6'h0D, rs, rt, imm};
      10: return {6'h0F, 5'd0, rt, imm};
      11, 12: return {6'h23, rs, rt, imm};
      13, 14: return {6'h2B, rs, rt, imm};
      15: return {6'h04, rs, rt, br};
      16: return {6'h05, rs, rt, br};
      17: return {6'h02, 26'((RESET_PC >> 2) + 32'($urandom_range(0, 63)))};
      18: return ($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)} : {6'h00, rs, rt, rd, 5'd0, 6'h21};
      default: return {6'h08, rs, rt, imm};
    endcase
  endfunction

  initial begin
    load_rom(0,  32'h2008_0005);  // addi $t0,$zero,5
    load_rom(1,  32'h2009_FFFD);  // addi $t1,$zero,-3
    load_rom(2,  32'h0109_5020);  // add  $t2,$t0,$t1
    load_rom(3,  32'h3C08_1001);  // lui  $t0,0x1001
    load_rom(4,  32'h2009_0055);  // addi $t1,$zero,0x55
    load_rom(5,  32'hAD09_0004);  // sw   $t1,4($t0)
    load_rom(6,  32'h8D0A_0004);  // lw   $t2,4($t0)
    load_rom(7,  32'h1000_0002);  // beq  $zero,$zero,+2
    load_rom(8,  32'hFC00_0000);
    load_rom(9,  32'hFC00_0000);
    load_rom(10, 32'h1400_0005);  // bne  $zero,$zero,+5
    load_rom(11, 32'hFC00_0000);  // illegal opcode 0x3F
    load_rom(12, 32'h200B_0007);  // addi $t3,$zero,7
    load_rom(13, 32'h0810_000D);  // j    0x00400034 (self)
    for (int i = 14; i < PDEPTH; i++) load_rom(i, 32'h0000_0000);
    for (int i = 0; i < DDEPTH; i++) begin
      m_ram[i] = '0;
      dut.data_ram[i] = '0;
    end

    do_reset();
    check_output("reset_pc", pc_o, 32'h0040_0000);
    check_output("reset_state", {29'd0, state_o}, 32'd0);
    check_output("reset_alu", alu_result_o, 32'd0);
    check_output("reset_retire", {31'd0, retire_o}, 32'd0);
    check_output("reset_illegal", {31'd0, illegal_o}, 32'd0);
    check_output("reset_cycle_count", cycle_count_o, 32'd0);
    check_output("reset_instr_count", instr_count_o, 32'd0);

    // Abort the first addi in its WB cycle: the register write must be dropped.
    repeat (3) @(negedge clk);
    check_output("abort_in_wb_state", {29'd0, state_o}, 32'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("abort_pc", pc_o, 32'h0040_0000);
    check_output("abort_state", {29'd0, state_o}, 32'd0);
    check_output("abort_t0", dut.regs_q[8], 32'd0);

    do_reset();
    apply_stimulus(3);
    check_output("add_t2_dut", dut.regs_q[10], 32'd2);
    check_output("add_t2_model", m_regs[10], 32'd2);
`ifdef MIPS_PERF_COUNTERS_EN
    check_output("perf_cycles_12", cycle_count_o, 32'd12);
    check_output("perf_instrs_3", instr_count_o, 32'd3);
`else
    check_output("perf_cycles_off", cycle_count_o, 32'd0);
    check_output("perf_instrs_off", instr_count_o, 32'd0);
`endif
    apply_stimulus(3);
    check_output("sw_ram1", dut.data_ram[1], 32'h0000_0055);
    apply_stimulus(1);
    check_output("lw_t2", dut.regs_q[10], 32'h0000_0055);
    check_output("lw_cpi_model", 32'(m_last_cpi), 32'd5);
    apply_stimulus(1);
    check_output("beq_taken_pc", pc_o, 32'h0040_0028);
    apply_stimulus(1);
    check_output("bne_not_taken_pc", pc_o, 32'h0040_002C);
    apply_stimulus(1);
    check_output("illegal_set", {31'd0, illegal_o}, 32'd1);
    check_output("illegal_next_pc", pc_o, 32'h0040_0030);
    check_output("illegal_cpi_model", 32'(m_last_cpi), 32'd2);
    apply_stimulus(1);
    check_output("addi_t3", dut.regs_q[11], 32'd7);
    apply_stimulus(4);
    check_output("jump_self_pc", pc_o, 32'h0040_0034);
    check_output("illegal_sticky", {31'd0, illegal_o}, 32'd1);

    // Randomized programs and RAM images, each from a fresh reset.
    for (int round = 0; round < 3; round++) begin
      for (int i = 0; i < PDEPTH; i++) load_rom(i, rand_instr());
      for (int i = 0; i < DDEPTH; i++) begin
        m_ram[i] = $urandom;
        dut.data_ram[i] = m_ram[i];
      end
      do_reset();
      apply_stimulus(150);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
